// File: rtl/byte_serial_alu.sv
// Byte-serial 32-bit ALU: operands read LSB slice first, result written back as four slices.
// Define BYTE_SERIAL_ALU_CMP_EN to build the SLT/SLTU comparison path.
module byte_serial_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] rs1_dat,
  input  logic [7:0] rs2_dat,
  output logic [1:0] byte_idx,
  output logic [7:0] rd_dat,
  output logic       rd_we,
  output logic       busy,
  output logic       done,
  output logic       zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
`ifdef BYTE_SERIAL_ALU_CMP_EN
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
`endif

  state_t      state;
  logic [2:0]  op_q;
  logic        carry;
  logic [31:0] result;

  logic        sub_sel;
  logic [7:0]  b_sel;
  logic        cin;
  logic [8:0]  sum;
  logic [7:0]  slice;
  logic [31:0] res_nxt;
  logic [1:0]  idx_nxt;
  logic        last;

`ifdef BYTE_SERIAL_ALU_CMP_EN
  logic cmp_op;
  logic slt_op;
  logic ovf;
  logic flag;
`endif

  assign idx_nxt = byte_idx + 2'd1;
  assign last    = (byte_idx == 2'd3);

  always_comb begin
    sub_sel = 1'b0;
`ifdef BYTE_SERIAL_ALU_CMP_EN
    cmp_op  = 1'b0;
    slt_op  = 1'b0;
`endif
    case (op_q)
      OP_SUB:  sub_sel = 1'b1;
`ifdef BYTE_SERIAL_ALU_CMP_EN
      OP_SLT: begin
        sub_sel = 1'b1;
        cmp_op  = 1'b1;
        slt_op  = 1'b1;
      end
      OP_SLTU: begin
        sub_sel = 1'b1;
        cmp_op  = 1'b1;
      end
`endif
      default: sub_sel = 1'b0;
    endcase

    // subtraction is A + ~B + 1, the +1 entering as carry-in at byte 0
    b_sel = sub_sel ? ~rs2_dat : rs2_dat;
    cin   = (byte_idx == 2'd0) ? sub_sel : carry;
    sum   = {1'b0, rs1_dat} + {1'b0, b_sel} + {8'd0, cin};

    case (op_q)
      OP_ADD,
      OP_SUB:  slice = sum[7:0];
      OP_AND:  slice = rs1_dat & rs2_dat;
      OP_OR:   slice = rs1_dat | rs2_dat;
      OP_XOR:  slice = rs1_dat ^ rs2_dat;
      default: slice = 8'd0;
    endcase

    res_nxt = result;
    res_nxt[{byte_idx, 3'b000} +: 8] = slice;

`ifdef BYTE_SERIAL_ALU_CMP_EN
    ovf  = (rs1_dat[7] == b_sel[7]) && (sum[7] != rs1_dat[7]);
    flag = slt_op ? (sum[7] ^ ovf) : ~sum[8];
    if (cmp_op && last)
      res_nxt = {31'd0, flag};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= 3'd0;
      carry    <= 1'b0;
      result   <= 32'd0;
      byte_idx <= 2'd0;
      rd_dat   <= 8'd0;
      rd_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          byte_idx <= 2'd0;
          rd_we    <= 1'b0;
          rd_dat   <= 8'd0;
          if (start) begin
            state  <= S_EXEC;
            op_q   <= op;
            carry  <= 1'b0;
            result <= 32'd0;
            busy   <= 1'b1;
            zero   <= 1'b0;
          end
        end
        S_EXEC: begin
          carry    <= sum[8];
          result   <= res_nxt;
          byte_idx <= idx_nxt;
          // slice 0 of WB must see the word including the byte just computed
          if (last) begin
            state  <= S_WB;
            rd_we  <= 1'b1;
            rd_dat <= res_nxt[7:0];
          end
        end
        S_WB: begin
          byte_idx <= idx_nxt;
          if (last) begin
            state  <= S_IDLE;
            rd_we  <= 1'b0;
            rd_dat <= 8'd0;
            busy   <= 1'b0;
            done   <= 1'b1;
            zero   <= (result == 32'd0);
          end else begin
            rd_dat <= result[{idx_nxt, 3'b000} +: 8];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/byte_serial_alu.md
BYTE_SERIAL_ALU -- requirements
Module: byte_serial_alu

Interface
REQ-001 Parameters: none; datapath fixed at 32-bit word, 8-bit slices, LSB slice first.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request new operation; sampled only in IDLE.
REQ-005 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 reserved.
REQ-006 rs1_dat  input  8  operand A slice selected by byte_idx.
REQ-007 rs2_dat  input  8  operand B slice selected by byte_idx.
REQ-008 byte_idx  output  2  slice index driven to the register file's phase select.
REQ-009 rd_dat  output  8  result slice for write-back.
REQ-010 rd_we  output  1  rd_dat valid; register file writes slice byte_idx.
REQ-011 busy  output  1  high in EXEC and WB.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 zero  output  1  32-bit result equals zero; valid while done high, held until next start accept.

Function
REQ-014 States: IDLE, EXEC, WB; transitions only on rising clk.
REQ-015 IDLE: start=1 -> EXEC, byte_idx=0, op latched; start=0 -> stay IDLE.
REQ-016 start while busy=1 shall be ignored; no queuing.
REQ-017 EXEC: 4 cycles, byte_idx 0,1,2,3; rs1_dat/rs2_dat sampled at edge ending each cycle as slice byte_idx.
REQ-018 EXEC byte 3 -> WB, byte_idx=0.
REQ-019 WB: 4 cycles, byte_idx 0..3, rd_we=1, rd_dat = result[8*byte_idx+7 : 8*byte_idx].
REQ-020 WB byte 3 -> IDLE; done=1 for exactly the first IDLE cycle; start in that cycle accepted.
REQ-021 Latency: start accepted edge T -> rd_we cycles T+5..T+8 (cycle index after edge) -> done cycle T+9; total 9 cycles start-to-done.
REQ-022 ADD: 8-bit adds chained through 1-bit carry register, carry-in 0 at byte 0; carry-out of byte 3 discarded (mod 2^32).
REQ-023 SUB: A + ~B + 1 via same chain, carry-in 1 at byte 0.
REQ-024 AND/OR/XOR: bitwise per slice, no carry.
REQ-025 SLT: result = 1 if signed A < B else 0, from (sign of A-B) XOR (signed overflow) at byte 3; upper 31 bits zero.
REQ-026 SLTU: result = 1 if borrow (carry-out 0) of A-B at byte 3, else 0.
REQ-027 op 7: result 32'h0000_0000, full normal sequence incl. rd_we.
REQ-028 Result held in 32-bit register; slices filled during EXEC, emitted unchanged in WB.
REQ-029 Outside WB: rd_we=0, rd_dat=0.
REQ-030 byte_idx=0 in IDLE.

Reset
REQ-031 rst_n low: immediately state IDLE, byte_idx=0, rd_dat=0, rd_we=0, busy=0, done=0, zero=0, carry=0, result=0.
REQ-032 Reset mid-EXEC or mid-WB aborts; no further rd_we after deassertion until new start.
REQ-033 First start honoured on first rising edge with rst_n high.

Configuration
REQ-034 Macro BYTE_SERIAL_ALU_CMP_EN defined: SLT/SLTU per REQ-025/026.
REQ-035 Macro undefined: ops 5 and 6 behave as op 7 (result 0, normal timing); comparison logic absent.

Verification
REQ-036 ADD A=0x0000_00FF, B=0x0000_0001 -> WB slices 00,01,00,00; result 0x0000_0100; done at cycle 9; zero=0.
REQ-037 SUB A=5, B=5 -> slices 00,00,00,00; zero=1 with done; carry propagation across all slices.
REQ-038 With CMP_EN: SLT A=0xFFFF_FFFF, B=1 -> result 1; SLTU same operands -> result 0; without CMP_EN both -> 0.
REQ-039 XOR A=0xA5A5_A5A5, B=0xFFFF_0000 -> 0x5A5A_A5A5; start pulsed during EXEC ignored, single done.
REQ-040 ADD in progress, rst_n low during WB byte 1 -> rd_we, busy, done drop immediately; after release with start=0, rd_we stays 0 for 20 cycles.
REQ-041 Back-to-back: start held high -> second op accepted in done cycle; rd_we pattern 4 on, 5 off, 4 on.
